// File: rtl/hamming_weight_pkg.sv
// Shared constants and FSM encoding for the Hamming-weight frame scheduler.
package hamming_weight_pkg;

    localparam logic [7:0]  START_WORD  = 8'hFF;
    localparam logic [7:0]  STOP_WORD   = 8'h00;
    localparam logic [7:0]  IDLE_WORD   = 8'h00;
    localparam int unsigned FRAME_BYTES = 128;
    localparam int unsigned WEIGHT_W    = 11;
    localparam int unsigned VEC_W       = FRAME_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT,
        RESP
    } fsm_state_t;

endpackage

// File: rtl/hamming_weight_rr_arb2.sv
// Two-way round-robin arbiter: grant follows the valid lines; on a tie the
// requester that was not granted last wins. Pointer moves only on accept.
module hamming_weight_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       grant_id,
    output logic       grant_valid
);

    logic last_id;

    // Combinational grant from the request lines and the last-granted pointer
    always_comb begin
        grant_valid = |valid;
        if (valid == 2'b11) begin
            grant_id = ~last_id;
        end else begin
            grant_id = valid[1];
        end
    end

    // Pointer starts at requester 1 so requester 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_id <= 1'b1;
        end else if (accept) begin
            last_id <= grant_id;
        end
    end

endmodule

// File: rtl/hamming_weight_frame_sched.sv
// Shares one hamming_weight_cal_rx between two requesters: serialises each
// 1024-bit vector as START, 128 data bytes (LSB byte first), STOP, then
// captures the calculator's weight and returns it tagged with the requester id.
module hamming_weight_frame_sched
    import hamming_weight_pkg::*;
#(
    parameter int unsigned RESULT_LAT = 2,
    parameter int unsigned IDLE_GAP   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [VEC_W-1:0]    req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [VEC_W-1:0]    req1_data,
    output logic                req1_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_id,
    output logic [WEIGHT_W-1:0] res_weight,
    output logic [7:0]          cal_bit_string,
    input  logic [WEIGHT_W-1:0] cal_hamming_weight
);

    localparam int unsigned BYTE_W = $clog2(FRAME_BYTES);
    localparam int unsigned LAT_W  = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
    localparam int unsigned GAP_W  = $clog2(IDLE_GAP + 1);

    fsm_state_t        state;
    logic [VEC_W-1:0]  shift_reg;
    logic [BYTE_W-1:0] byte_cnt;
    logic [BYTE_W-1:0] byte_next;
    logic [LAT_W-1:0]  lat_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              gap_done;
    logic              frame_id;
    logic              grant_id;
    logic              grant_valid;
    logic              accept;

    hamming_weight_rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .valid       ({req1_valid, req0_valid}),
        .accept      (accept),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Ready/accept decode; gap_cnt counts IDLE cycles including the current one
    always_comb begin
        gap_done   = (gap_cnt >= GAP_W'(IDLE_GAP));
        accept     = (state == IDLE) && gap_done && grant_valid && !rst;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        byte_next  = byte_cnt + 1'b1;
    end

    // Frame FSM with registered byte stream and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cal_bit_string <= IDLE_WORD;
            shift_reg      <= '0;
            byte_cnt       <= '0;
            lat_cnt        <= '0;
            gap_cnt        <= GAP_W'(IDLE_GAP);
            frame_id       <= 1'b0;
            res_valid      <= 1'b0;
            res_id         <= 1'b0;
            res_weight     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cal_bit_string <= IDLE_WORD;
                    if (!gap_done) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                    if (accept) begin
                        shift_reg      <= grant_id ? req1_data : req0_data;
                        frame_id       <= grant_id;
                        cal_bit_string <= START_WORD;
                        state          <= START;
                    end
                end
                START: begin
                    cal_bit_string <= shift_reg[7:0];
                    shift_reg      <= shift_reg >> 8;
                    byte_cnt       <= '0;
                    state          <= DATA;
                end
                DATA: begin
                    byte_cnt <= byte_next;
                    if (byte_next == '0) begin
                        cal_bit_string <= STOP_WORD;
                        state          <= STOP;
                    end else begin
                        cal_bit_string <= shift_reg[7:0];
                        shift_reg      <= shift_reg >> 8;
                    end
                end
                STOP: begin
                    cal_bit_string <= IDLE_WORD;
                    lat_cnt        <= '0;
                    state          <= WAIT;
                end
                WAIT: begin
                    cal_bit_string <= IDLE_WORD;
                    if (lat_cnt == LAT_W'(RESULT_LAT - 1)) begin
                        res_weight <= cal_hamming_weight;
                        res_id     <= frame_id;
                        res_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                RESP: begin
                    cal_bit_string <= IDLE_WORD;
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        gap_cnt   <= GAP_W'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    cal_bit_string <= IDLE_WORD;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_weight_frame_sched.sv
// Scoreboard bench for hamming_weight_frame_sched with a behavioural
// hamming_weight_cal_rx stand-in that decodes the framed byte stream.
module tb_hamming_weight_frame_sched;

    localparam int RL      = 2;
    localparam int GAP     = 1;
    localparam int LATENCY = 130 + RL + 1;
    localparam int PERIOD  = 131 + RL + GAP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic [1023:0] req0_data  = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [1023:0] req1_data  = '0;
    logic          req1_ready;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic          res_id;
    logic [10:0]   res_weight;
    logic [7:0]    cal_bit_string;
    logic [10:0]   cal_hamming_weight = '0;

    hamming_weight_frame_sched #(
        .RESULT_LAT (RL),
        .IDLE_GAP   (GAP)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req0_valid         (req0_valid),
        .req0_data          (req0_data),
        .req0_ready         (req0_ready),
        .req1_valid         (req1_valid),
        .req1_data          (req1_data),
        .req1_ready         (req1_ready),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_id             (res_id),
        .res_weight         (res_weight),
        .cal_bit_string     (cal_bit_string),
        .cal_hamming_weight (cal_hamming_weight)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit id;
        int w;
        int acc;
    } exp_t;

    exp_t          exp_q[$];
    logic [1023:0] frame_q[$];
    int            start_cycles[$];
    bit            acc_ids[$];

    bit            in_frame   = 1'b0;
    int            nbytes     = 0;
    logic [1023:0] coll       = '0;
    int            stop_cyc   = -100;
    int            rx_w       = 0;
    bit            prev_valid = 1'b0;
    bit            rand_rdy   = 1'b0;

    // Monitor: records accepts, models the calculator, scores results
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            frame_q.delete();
            in_frame   = 1'b0;
            stop_cyc   = -100;
            prev_valid = 1'b0;
            cal_hamming_weight = 11'($urandom);
        end else begin
            if (req0_valid && req0_ready) begin
                exp_q.push_back('{1'b0, $countones(req0_data), cyc});
                frame_q.push_back(req0_data);
                acc_ids.push_back(1'b0);
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back('{1'b1, $countones(req1_data), cyc});
                frame_q.push_back(req1_data);
                acc_ids.push_back(1'b1);
            end

            if (in_frame) begin
                if (nbytes < 128) begin
                    coll[nbytes*8 +: 8] = cal_bit_string;
                    nbytes++;
                end else begin
                    chk("stop_word", cal_bit_string, 8'h00);
                    in_frame = 1'b0;
                    stop_cyc = cyc;
                    rx_w     = $countones(coll);
                    chk("frame_pending", frame_q.size(), 1);
                    if (frame_q.size() != 0) begin
                        chk("frame_bytes", coll == frame_q[0], 1);
                        void'(frame_q.pop_front());
                    end
                end
            end else if (cal_bit_string == 8'hFF) begin
                in_frame = 1'b1;
                nbytes   = 0;
                start_cycles.push_back(cyc);
            end
            cal_hamming_weight = (cyc == stop_cyc + RL) ? 11'(rx_w) : 11'($urandom);

            if (res_valid) begin
                chk("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    if (!prev_valid) chk("latency", cyc - exp_q[0].acc, LATENCY);
                    if (res_ready) begin
                        chk("res_id", res_id, exp_q[0].id);
                        chk("res_weight", res_weight, exp_q[0].w);
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_valid = res_valid && !res_ready;
        end
    end

    // Randomised consumer back-pressure when enabled
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) res_ready = ($urandom % 3) != 0;
    end

    function automatic logic [1023:0] rand_vec();
        logic [1023:0] a;
        logic [1023:0] b;
        for (int i = 0; i < 32; i++) begin
            a[i*32 +: 32] = $urandom;
            b[i*32 +: 32] = $urandom;
        end
        case ($urandom_range(0, 2))
            0:       return a;
            1:       return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic send(input bit id, input logic [1023:0] d);
        bit done = 1'b0;
        if (id) begin req1_data = d; req1_valid = 1'b1; end
        else    begin req0_data = d; req0_valid = 1'b1; end
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) done = 1'b1;
        end
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
        chk("send_accepted", done, 1);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while ((exp_q.size() != 0 || res_valid) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("drain_in_budget", i < budget, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] v;
        logic [1023:0] v2;
        logic [10:0]   w0;
        int            ns;
        int            na;

        // Reset values
        @(negedge clk);
        chk("rst_cal", cal_bit_string, 8'h00);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_weight", res_weight, 0);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single set bit at position 31 (data byte 3 = 0x80)
        v = '0;
        v[31] = 1'b1;
        send(0, v);
        wait_idle(400);

        // All ones from requester 1
        send(1, '1);
        wait_idle(400);

        // Both valid on the first cycle after reset: requester 0 first
        do_reset();
        na = acc_ids.size();
        req0_data = 1024'h0F; req0_valid = 1'b1;
        req1_data = 1024'h3;  req1_valid = 1'b1;
        #1;
        chk("tie_ready0", req0_ready, 1);
        chk("tie_ready1", req1_ready, 0);
        fork
            send(0, 1024'h0F);
            send(1, 1024'h3);
        join
        wait_idle(400);
        chk("tie_accepts", acc_ids.size(), na + 2);
        if (acc_ids.size() == na + 2) begin
            chk("tie_first_id", acc_ids[na], 0);
            chk("tie_second_id", acc_ids[na+1], 1);
        end

        // Consumer stalls for 20 cycles while another request waits
        res_ready = 1'b0;
        v = rand_vec();
        send(0, v);
        for (int i = 0; i < 300 && !res_valid; i++) @(negedge clk);
        chk("stall_res_valid", res_valid, 1);
        w0 = res_weight;
        v2 = rand_vec();
        req1_data = v2;
        req1_valid = 1'b1;
        ns = start_cycles.size();
        repeat (20) begin
            @(negedge clk);
            chk("stall_valid_held", res_valid, 1);
            chk("stall_weight_held", res_weight, w0);
            chk("stall_cal_idle", cal_bit_string, 8'h00);
            chk("stall_req1_blocked", req1_ready, 0);
        end
        chk("stall_no_start", start_cycles.size(), ns);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        send(1, v2);
        wait_idle(400);

        // Reset during data byte 60, then a fresh complete frame
        v = rand_vec();
        send(0, v);
        repeat (61) @(posedge clk);
        #1;
        chk("midframe_byte60", cal_bit_string, v[487:480]);
        rst = 1'b1;
        #1;
        chk("midframe_rst_cal", cal_bit_string, 8'h00);
        chk("midframe_rst_valid", res_valid, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ns = start_cycles.size();
        send(1, rand_vec());
        wait_idle(400);
        chk("midframe_fresh_frame", start_cycles.size(), ns + 1);

        // Back-to-back frames: minimum period START to START
        ns = start_cycles.size();
        send(0, rand_vec());
        send(0, rand_vec());
        wait_idle(400);
        chk("b2b_frames", start_cycles.size(), ns + 2);
        if (start_cycles.size() == ns + 2)
            chk("b2b_period", start_cycles[ns+1] - start_cycles[ns], PERIOD);

        // Random traffic from both requesters with random back-pressure
        rand_rdy = 1'b1;
        fork
            for (int i = 0; i < 4; i++) send(0, rand_vec());
            for (int j = 0; j < 4; j++) send(1, rand_vec());
        join
        rand_rdy = 1'b0;
        #2;
        res_ready = 1'b1;
        wait_idle(600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
